isb_stream_predictor: RTL and testbench



---
 rtl/isb_pkg.sv | 24 ++
 rtl/isb_pf_fifo.sv | 66 ++++++
 rtl/isb_stream_predictor.sv | 109 ++++++++++
 tb/tb_isb_stream_predictor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isb_pkg.sv
// Shared ISB prefetcher definitions: address widths, stream geometry and the
// prediction-walk state encoding used by both training and prediction blocks.
package isb_pkg;

  localparam int SA_W        = 32;
  localparam int PA_W        = 16;
  localparam int STREAM_LEN  = 16;
  localparam int STREAM_BITS = $clog2(STREAM_LEN);

  typedef logic [SA_W-1:0] sa_t;
  typedef logic [PA_W-1:0] pa_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } isb_state_t;

  // True when the SA is the first slot of a 16-SA structural stream.
  function automatic logic at_stream_start(input sa_t sa);
    return sa[STREAM_BITS-1:0] == '0;
  endfunction

endpackage

// File: rtl/isb_pf_fifo.sv
// Circular prefetch stream buffer with push, pop, synchronous flush and a view
// of every stored entry plus its valid bit for duplicate filtering.
module isb_pf_fifo #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 2,
  localparam int DEPTH     = 2**DEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [W-1:0]             head,
  output logic [DEPTH-1:0][W-1:0]  entries,
  output logic [DEPTH-1:0]         entry_v
);

  localparam int PW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [CW-1:0]           count;
  logic [PW-1:0]           offs [DEPTH];
  logic                    do_push;
  logic                    do_pop;

  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign head    = mem[rd_ptr];
  assign entries = mem;
  assign do_pop  = pop && !empty;
  // A push into a full buffer is accepted only when the head leaves that cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offs[i]    = PW'(i) - rd_ptr;
      entry_v[i] = {1'b0, offs[i]} < count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/isb_stream_predictor.sv
// ISB prediction walk: on a trigger, read consecutive SAs from the SP-AMC and
// queue their PAs for prefetch. Optional macro ISB_PF_FILTER_EN drops duplicate PAs.
module isb_stream_predictor
  import isb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int DEGREE     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trig_v,
  input  logic [SA_W-1:0] trig_sa,
  output logic            sp_rd_v,
  output logic [SA_W-1:0] sp_rd_sa,
  input  logic            sp_rd_hit,
  input  logic [PA_W-1:0] sp_rd_pa,
  output logic            prefetch_v,
  output logic [PA_W-1:0] prefetch_addr,
  input  logic            prefetch_ready,
  output logic            busy
);

  localparam int         DEPTH = 2**DEPTH_LOG2;
  localparam logic [4:0] DEG   = 5'(DEGREE);
`ifdef ISB_PF_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  isb_state_t                 state;
  sa_t                        cursor;
  sa_t                        cursor_inc;
  logic [4:0]                 cnt;
  logic [4:0]                 cnt_inc;
  logic                       full;
  logic                       empty;
  pa_t                        head;
  logic [DEPTH-1:0][PA_W-1:0] entries;
  logic [DEPTH-1:0]           entry_v;
  logic [DEPTH-1:0]           match;
  logic                       dup;
  logic                       resp_hit;
  logic                       push;
  logic                       pop;

  assign cursor_inc = cursor + sa_t'(1);
  assign cnt_inc    = cnt + 5'd1;

  // Prefetch handshake: the head is offered while prefetch_v is high and leaves
  // on every cycle with prefetch_v && prefetch_ready; a trigger flush overrides that pop.
  always_comb begin
    sp_rd_v       = (state == REQ) && !full;
    sp_rd_sa      = sp_rd_v ? cursor : '0;
    prefetch_v    = !empty;
    prefetch_addr = empty ? '0 : head;
    busy          = state != IDLE;
    for (int i = 0; i < DEPTH; i++) match[i] = entries[i] == sp_rd_pa;
    dup           = |(match & entry_v);
    resp_hit      = (state == RESP) && sp_rd_hit && !trig_v;
    push          = resp_hit && !(FILTER_EN && dup);
    pop           = prefetch_v && prefetch_ready && !trig_v;
  end

  isb_pf_fifo #(
    .W          (PA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (trig_v),
    .push      (push),
    .push_data (sp_rd_pa),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .entries   (entries),
    .entry_v   (entry_v)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cursor <= '0;
      cnt    <= '0;
    end else if (trig_v) begin
      // A trigger restarts the walk and drops whatever response is in flight.
      cursor <= trig_sa + sa_t'(1);
      cnt    <= '0;
      state  <= at_stream_start(trig_sa + sa_t'(1)) ? IDLE : REQ;
    end else begin
      case (state)
        REQ: if (!full) state <= RESP;
        RESP: begin
          if (sp_rd_hit) begin
            cursor <= cursor_inc;
            cnt    <= cnt_inc;
            state  <= (cnt_inc == DEG || at_stream_start(cursor_inc)) ? IDLE : REQ;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isb_stream_predictor.sv
// Directed bench for isb_stream_predictor: one DEGREE=4 and one DEGREE=1 instance,
// each fed by a registered SP-AMC model, checked by a table of walks plus corner sequences.
module tb_isb_stream_predictor;
  import isb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        trig_v, trig_v1;
  logic [31:0] trig_sa;
  logic        prefetch_ready;

  logic        sp_rd_v, sp_rd_v1;
  logic [31:0] sp_rd_sa, sp_rd_sa1;
  logic        sp_rd_hit = 1'b0, sp_rd_hit1 = 1'b0;
  logic [15:0] sp_rd_pa = '0, sp_rd_pa1 = '0;
  logic        prefetch_v, prefetch_v1;
  logic [15:0] prefetch_addr, prefetch_addr1;
  logic        busy, busy1;

  logic [31:0] miss_sa;
  logic [31:0] req_q[$];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  isb_stream_predictor #(.DEPTH_LOG2(2), .DEGREE(4)) u_dut (
    .clk(clk), .reset(reset), .trig_v(trig_v), .trig_sa(trig_sa),
    .sp_rd_v(sp_rd_v), .sp_rd_sa(sp_rd_sa), .sp_rd_hit(sp_rd_hit), .sp_rd_pa(sp_rd_pa),
    .prefetch_v(prefetch_v), .prefetch_addr(prefetch_addr),
    .prefetch_ready(prefetch_ready), .busy(busy)
  );

  isb_stream_predictor #(.DEPTH_LOG2(2), .DEGREE(1)) u_deg1 (
    .clk(clk), .reset(reset), .trig_v(trig_v1), .trig_sa(trig_sa),
    .sp_rd_v(sp_rd_v1), .sp_rd_sa(sp_rd_sa1), .sp_rd_hit(sp_rd_hit1), .sp_rd_pa(sp_rd_pa1),
    .prefetch_v(prefetch_v1), .prefetch_addr(prefetch_addr1),
    .prefetch_ready(prefetch_ready), .busy(busy1)
  );

  // SP-AMC contents: a few fixed mappings, everything else maps to {C0, sa[7:0]}.
  function automatic logic [15:0] pa_of(input logic [31:0] sa);
    if (sa == 32'h21) return 16'h1234;
    if (sa == 32'h71 || sa == 32'h72) return 16'hAAAA;
    return {8'hC0, sa[7:0]};
  endfunction

  always @(posedge clk) begin
    sp_rd_hit  <= sp_rd_v && (sp_rd_sa != miss_sa);
    sp_rd_pa   <= pa_of(sp_rd_sa);
    sp_rd_hit1 <= sp_rd_v1;
    sp_rd_pa1  <= pa_of(sp_rd_sa1);
    if (sp_rd_v) req_q.push_back(sp_rd_sa);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at a negedge once the DEGREE=4 instance is idle, or after a cycle budget.
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, " idle"}, busy, 0);
  endtask

  // Called at a negedge: release ready and compare every popped head with exp_q.
  task automatic drain(input string name);
    logic [15:0] e;
    prefetch_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (!prefetch_v) break;
      if (exp_q.size() == 0) begin
        check({name, " extra entry"}, prefetch_addr, 16'hxxxx);
      end else begin
        e = exp_q.pop_front();
        check({name, " drain pa"}, prefetch_addr, e);
      end
      @(negedge clk);
    end
    check({name, " missing entries"}, exp_q.size(), 0);
    check({name, " empty after drain"}, prefetch_v, 0);
    prefetch_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] trig_sa;
    logic [31:0] miss_sa;
    int          reqs;
    int          pushes;
  } walk_vec_t;

  walk_vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"deg4_0x40",     32'h40,        32'hDEADBEEF, 4, 4};
    vecs[1] = '{"bound_0x0D",    32'h0D,        32'hDEADBEEF, 2, 2};
    vecs[2] = '{"bound_0x0F",    32'h0F,        32'hDEADBEEF, 0, 0};
    vecs[3] = '{"deg_bound_1B",  32'h1B,        32'hDEADBEEF, 4, 4};
    vecs[4] = '{"bound_0x1C",    32'h1C,        32'hDEADBEEF, 3, 3};
    vecs[5] = '{"wrap_FFFFFFFE", 32'hFFFFFFFE,  32'hDEADBEEF, 1, 1};
    vecs[6] = '{"wrap_FFFFFFFF", 32'hFFFFFFFF,  32'hDEADBEEF, 0, 0};
    vecs[7] = '{"miss_0x52",     32'h50,        32'h52,       2, 1};
    vecs[8] = '{"miss_first",    32'h30,        32'h31,       1, 0};

    reset = 1'b1; trig_v = 1'b0; trig_v1 = 1'b0; trig_sa = '0;
    prefetch_ready = 1'b0; miss_sa = 32'hDEADBEEF;
    step();
    @(negedge clk);
    check("reset sp_rd_v", {sp_rd_v, sp_rd_v1}, 0);
    check("reset sp_rd_sa", {sp_rd_sa, sp_rd_sa1}, 0);
    check("reset prefetch_v", {prefetch_v, prefetch_v1}, 0);
    check("reset prefetch_addr", {prefetch_addr, prefetch_addr1}, 0);
    check("reset busy", {busy, busy1}, 0);
    step();
    reset = 1'b0;

    // DEGREE=1 latency: trigger at N, request at N+1, prefetch at N+3.
    trig_v1 = 1'b1; trig_sa = 32'h20;
    step();
    trig_v1 = 1'b0;
    @(negedge clk);
    check("lat N+1 sp_rd_v", sp_rd_v1, 1);
    check("lat N+1 sp_rd_sa", sp_rd_sa1, 32'h21);
    check("lat N+1 busy", busy1, 1);
    step();
    @(negedge clk);
    check("lat N+2 sp_rd_v", sp_rd_v1, 0);
    check("lat N+2 prefetch_v", prefetch_v1, 0);
    step();
    @(negedge clk);
    check("lat N+3 prefetch_v", prefetch_v1, 1);
    check("lat N+3 prefetch_addr", prefetch_addr1, 16'h1234);
    check("lat N+3 busy", busy1, 0);
    prefetch_ready = 1'b1;
    step();
    prefetch_ready = 1'b0;
    @(negedge clk);
    check("deg1 pop empties", prefetch_v1, 0);
    check("deg1 no second req", sp_rd_v1, 0);

    // Table of DEGREE=4 walks with ready held low, then drained in order.
    foreach (vecs[v]) begin
      miss_sa = vecs[v].miss_sa;
      prefetch_ready = 1'b0;
      req_q.delete();
      exp_q.delete();
      step();
      trig_v = 1'b1; trig_sa = vecs[v].trig_sa;
      step();
      trig_v = 1'b0;
      wait_idle(vecs[v].name);
      check({vecs[v].name, " req count"}, req_q.size(), vecs[v].reqs);
      for (int i = 0; i < vecs[v].reqs && i < req_q.size(); i++)
        check({vecs[v].name, " req sa"}, req_q[i], vecs[v].trig_sa + 32'(i + 1));
      for (int i = 0; i < vecs[v].pushes; i++)
        exp_q.push_back(pa_of(vecs[v].trig_sa + 32'(i + 1)));
      drain(vecs[v].name);
      check({vecs[v].name, " no late req"}, req_q.size(), vecs[v].reqs);
    end

    // Retrigger while a hit is pending in RESP: old PA is dropped.
    miss_sa = 32'hDEADBEEF;
    req_q.delete();
    exp_q.delete();
    step();
    trig_v = 1'b1; trig_sa = 32'h60;
    step();
    trig_v = 1'b0;
    step();
    trig_v = 1'b1; trig_sa = 32'h80;
    @(negedge clk);
    check("retrig in RESP busy", busy, 1);
    step();
    trig_v = 1'b0;
    @(negedge clk);
    check("retrig sp_rd_v", sp_rd_v, 1);
    check("retrig sp_rd_sa", sp_rd_sa, 32'h81);
    check("retrig old pa dropped", prefetch_v, 0);
    wait_idle("retrig");
    check("retrig req count", req_q.size(), 5);
    for (int i = 0; i < 4; i++) exp_q.push_back(pa_of(32'h81 + 32'(i)));
    drain("retrig");

    // Two SAs mapping to the same PA.
    req_q.delete();
    exp_q.delete();
    step();
    trig_v = 1'b1; trig_sa = 32'h70;
    step();
    trig_v = 1'b0;
    wait_idle("dup");
    check("dup req count", req_q.size(), 4);
    exp_q.push_back(16'hAAAA);
`ifndef ISB_PF_FILTER_EN
    exp_q.push_back(16'hAAAA);
`endif
    exp_q.push_back(16'hC073);
    exp_q.push_back(16'hC074);
    drain("dup");

    // Reset in the middle of a walk with entries buffered.
    begin
      bit found;
      found = 1'b0;
      step();
      trig_v = 1'b1; trig_sa = 32'h00;
      step();
      trig_v = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (sp_rd_v && sp_rd_sa == 32'h04) begin
          found = 1'b1;
          break;
        end
      end
      check("midreset reached 4th req", found, 1);
      check("midreset buffer nonempty", prefetch_v, 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("midreset prefetch_v", prefetch_v, 0);
      check("midreset sp_rd_v", sp_rd_v, 0);
      check("midreset busy", busy, 0);
      check("midreset prefetch_addr", prefetch_addr, 0);
      step();
      step();
      @(negedge clk);
      check("post reset still idle", {sp_rd_v, prefetch_v, busy}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
